// File: rtl/scan_table_loader_if.sv
// Host word-stream channel into the scan table loader: valid/ready handshake
// carrying one 16-bit table word per accepted transfer.
`timescale 1ns/1ps
interface scan_table_loader_if;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;

    // Host side: drives words, observes acceptance
    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    // Loader side: consumes words, signals acceptance
    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );
endinterface

// File: rtl/scan_table_loader.sv
// scan_table_loader: fills the X then Y waveform tables from a host stream,
// serves the generator's registered read ports, pulses frame_rdy when both
// tables are complete and locks them until proc_finished or KILL_PROCESS.
`timescale 1ns/1ps
module scan_table_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              KILL_PROCESS,
    input  logic              load_start,
    input  logic [15:0]       xdata_points_number,
    input  logic [15:0]       ydata_points_number,
    scan_table_loader_if.slave wr,
    input  logic [ADDR_W-1:0] sg_x_addr,
    output logic [15:0]       sg_x_data,
    input  logic [ADDR_W-1:0] sg_y_addr,
    output logic [15:0]       sg_y_data,
    input  logic              proc_finished,
    output logic              frame_rdy,
    output logic              loading,
    output logic              table_busy,
    output logic              table_err
);
    localparam int          DEPTH   = 2 ** ADDR_W;
    localparam int          CW      = ADDR_W + 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD_X, LOAD_Y, RUN} state_t;

    state_t        state_q, state_d;
    // One bit wider than the address so a full-depth count is reachable
    logic [CW-1:0] waddr_q, waddr_d;
    logic [CW-1:0] waddr_inc;
    logic [15:0]   xcount_q, xcount_d;
    logic [15:0]   ycount_q, ycount_d;
    logic          table_err_q, table_err_d;
    logic          frame_rdy_q, frame_rdy_d;

    logic          accepting;
    logic          handshake;
    logic          last_x, last_y;
    logic          counts_legal;
    logic [1:0]    tbl_we;
    logic [ADDR_W-1:0] tbl_raddr [2];
    logic [15:0]       tbl_rdata [2];

    // A count is legal in 1..DEPTH, compared unsigned
    function automatic logic count_legal(input logic [15:0] c);
        return (c != 16'd0) && (32'(c) <= DEPTH_U);
    endfunction

    assign accepting    = (state_q == LOAD_X) || (state_q == LOAD_Y);
    assign handshake    = accepting && wr.wr_valid;
    assign waddr_inc    = waddr_q + {{(CW-1){1'b0}}, 1'b1};
    assign last_x       = (16'(waddr_inc) == xcount_q);
    assign last_y       = (16'(waddr_inc) == ycount_q);
    assign counts_legal = count_legal(xdata_points_number) &&
                          count_legal(ydata_points_number);

    // Next-state, counter and table write-enable logic; kill overrides all
    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        xcount_d    = xcount_q;
        ycount_d    = ycount_q;
        table_err_d = table_err_q;
        frame_rdy_d = 1'b0;
        tbl_we      = 2'b00;
        if (KILL_PROCESS) begin
            // Abort: back to IDLE, no write this cycle, error flag untouched
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        if (counts_legal) begin
                            xcount_d    = xdata_points_number;
                            ycount_d    = ydata_points_number;
                            table_err_d = 1'b0;
                            waddr_d     = '0;
                            state_d     = LOAD_X;
                        end else begin
                            table_err_d = 1'b1;
                        end
                    end
                end
                LOAD_X: begin
                    if (handshake) begin
                        tbl_we[0] = 1'b1;
                        if (last_x) begin
                            waddr_d = '0;
                            state_d = LOAD_Y;
                        end else begin
                            waddr_d = waddr_inc;
                        end
                    end
                end
                LOAD_Y: begin
                    if (handshake) begin
                        tbl_we[1] = 1'b1;
                        if (last_y) begin
                            waddr_d     = '0;
                            frame_rdy_d = 1'b1;
                            state_d     = RUN;
                        end else begin
                            waddr_d = waddr_inc;
                        end
                    end
                end
                RUN: begin
                    if (proc_finished) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            xcount_q    <= '0;
            ycount_q    <= '0;
            table_err_q <= 1'b0;
            frame_rdy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            xcount_q    <= xcount_d;
            ycount_q    <= ycount_d;
            table_err_q <= table_err_d;
            frame_rdy_q <= frame_rdy_d;
        end
    end

    assign tbl_raddr[0] = sg_x_addr;
    assign tbl_raddr[1] = sg_y_addr;

    // Table 0 is X, table 1 is Y; both share the write word and address
    for (genvar gi = 0; gi < 2; gi++) begin : g_table
        logic [15:0] mem [DEPTH];
        logic [15:0] rdata_q;

        // Write port; contents survive reset
        always_ff @(posedge sys_clk) begin
            if (tbl_we[gi]) begin
                mem[waddr_q[ADDR_W-1:0]] <= wr.wr_data;
            end
        end

        // Registered read, read-before-write on address collision
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= mem[tbl_raddr[gi]];
            end
        end

        assign tbl_rdata[gi] = rdata_q;
    end

    assign sg_x_data   = tbl_rdata[0];
    assign sg_y_data   = tbl_rdata[1];
    assign wr.wr_ready = accepting;
    assign loading     = accepting;
    assign table_busy  = (state_q == RUN);
    assign frame_rdy   = frame_rdy_q;
    assign table_err   = table_err_q;
endmodule
